// File: rtl/pe_pkg.sv
// Shared definitions for the CGRA processing element: opcodes, operand/destination
// codes and the instruction word layout.
package pe_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned NPORT  = 5;

  typedef enum logic [CODE_W-1:0] {
    OP_NOP    = 4'd0,
    OP_AND    = 4'd1,
    OP_XOR    = 4'd2,
    OP_OR     = 4'd3,
    OP_NOT    = 4'd4,
    OP_ADD    = 4'd5,
    OP_SUB    = 4'd6,
    OP_MUL    = 4'd7,
    OP_DIV    = 4'd8,
    OP_SHL    = 4'd9,
    OP_SHR    = 4'd10,
    OP_LT     = 4'd11,
    OP_PASS   = 4'd12,
    OP_RSV13  = 4'd13,
    OP_RSV14  = 4'd14,
    OP_RSV15  = 4'd15
  } op_e;

  // Operand source codes; register k is SRC_REG0 + k.
  localparam logic [CODE_W-1:0] SRC_E    = 4'd0;
  localparam logic [CODE_W-1:0] SRC_S    = 4'd1;
  localparam logic [CODE_W-1:0] SRC_W    = 4'd2;
  localparam logic [CODE_W-1:0] SRC_N    = 4'd3;
  localparam logic [CODE_W-1:0] SRC_REG0 = 4'd4;
  localparam logic [CODE_W-1:0] SRC_IMM  = 4'd15;

  // Destination codes; register k is DST_REG0 + k.
  localparam logic [CODE_W-1:0] DST_E    = 4'd0;
  localparam logic [CODE_W-1:0] DST_S    = 4'd1;
  localparam logic [CODE_W-1:0] DST_W    = 4'd2;
  localparam logic [CODE_W-1:0] DST_N    = 4'd3;
  localparam logic [CODE_W-1:0] DST_MEM  = 4'd4;
  localparam logic [CODE_W-1:0] DST_REG0 = 4'd5;

  typedef struct packed {
    logic [CODE_W-1:0] dst;
    logic [CODE_W-1:0] src1;
    logic [CODE_W-1:0] src2;
    op_e               op;
  } ctrl_t;

  function automatic logic [CODE_W-1:0] ctrl_dst(input logic [CTRL_W-1:0] c);
    ctrl_t t;
    t = ctrl_t'(c);
    return t.dst;
  endfunction

  function automatic logic [CODE_W-1:0] ctrl_src1(input logic [CTRL_W-1:0] c);
    ctrl_t t;
    t = ctrl_t'(c);
    return t.src1;
  endfunction

  function automatic logic [CODE_W-1:0] ctrl_src2(input logic [CTRL_W-1:0] c);
    ctrl_t t;
    t = ctrl_t'(c);
    return t.src2;
  endfunction

  function automatic op_e ctrl_op(input logic [CTRL_W-1:0] c);
    ctrl_t t;
    t = ctrl_t'(c);
    return t.op;
  endfunction

  // Reserved opcodes behave exactly like NOP.
  function automatic logic op_is_nop(input op_e op);
    return (op == OP_NOP) || (op > OP_PASS);
  endfunction

endpackage

// File: rtl/pe_alu.sv
// Combinational ALU of the processing element; all arithmetic is unsigned modulo 2^DATA_W.
module pe_alu
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic              div0
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;

  assign shamt = op2[SH_W-1:0];

  // Operation select; NOP and reserved codes produce zero.
  always_comb begin
    result = '0;
    div0   = 1'b0;
    case (op)
      OP_AND:  result = op1 & op2;
      OP_XOR:  result = op1 ^ op2;
      OP_OR:   result = op1 | op2;
      OP_NOT:  result = ~op1;
      OP_ADD:  result = op1 + op2;
      OP_SUB:  result = op1 - op2;
      OP_MUL:  result = DATA_W'(op1 * op2);
      OP_DIV: begin
        if (op2 == '0) begin
          result = '1;
          div0   = 1'b1;
        end else begin
          result = op1 / op2;
        end
      end
      OP_SHL:  result = op1 << shamt;
      OP_SHR:  result = op1 >> shamt;
      OP_LT:   result = {{(DATA_W-1){1'b0}}, (op1 < op2)};
      OP_PASS: result = op1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pe_pipe.sv
// Two-stage CGRA processing element: operand capture (stage A) feeding a shared
// output register (stage B) with per-port valid/ready, plus a local register file.
module pe_pipe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] E,
  input  logic [DATA_W-1:0] S,
  input  logic [DATA_W-1:0] W,
  input  logic [DATA_W-1:0] N,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NPORT-1:0]  out_valid,
  input  logic [NPORT-1:0]  out_ready,
  output logic              err_div0,
  input  logic              err_clr
);

  // Stage A token
  logic              a_valid;
  op_e               a_op;
  logic [CODE_W-1:0] a_dst;
  logic [DATA_W-1:0] a_op1;
  logic [DATA_W-1:0] a_op2;

  // Register file and its forwarded view
  logic [NREG-1:0][DATA_W-1:0] rf;
  logic [NREG-1:0][DATA_W-1:0] rf_fwd;
  logic [NREG-1:0]             wr_hit;

  logic [DATA_W-1:0] alu_res;
  logic              alu_div0;
  logic [DATA_W-1:0] op1_nxt;
  logic [DATA_W-1:0] op2_nxt;
  logic [NPORT-1:0]  a_port_sel;
  logic              a_nop;
  logic              a_to_port;
  logic              b_drain;
  logic              b_free;
  logic              a_adv;
  logic              accept;

  // Operand mux: neighbour links, forwarded registers, immediate, else zero.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [CODE_W-1:0]           sel,
    input logic [DATA_W-1:0]           e_val,
    input logic [DATA_W-1:0]           s_val,
    input logic [DATA_W-1:0]           w_val,
    input logic [DATA_W-1:0]           n_val,
    input logic [DATA_W-1:0]           imm_val,
    input logic [NREG-1:0][DATA_W-1:0] regs
  );
    logic [DATA_W-1:0] v;
    v = '0;
    case (sel)
      SRC_E:   v = e_val;
      SRC_S:   v = s_val;
      SRC_W:   v = w_val;
      SRC_N:   v = n_val;
      SRC_IMM: v = imm_val;
      default: v = '0;
    endcase
    for (int unsigned k = 0; k < NREG; k++) begin
      if (sel == 4'(SRC_REG0 + k)) v = regs[k];
    end
    return v;
  endfunction

  pe_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (a_op),
    .op1    (a_op1),
    .op2    (a_op2),
    .result (alu_res),
    .div0   (alu_div0)
  );

  // Decode where the stage-A token retires: an output port or a register.
  always_comb begin
    a_port_sel = '0;
    case (a_dst)
      DST_E:   a_port_sel = 5'b00001;
      DST_S:   a_port_sel = 5'b00010;
      DST_W:   a_port_sel = 5'b00100;
      DST_N:   a_port_sel = 5'b01000;
      DST_MEM: a_port_sel = 5'b10000;
      default: a_port_sel = '0;
    endcase
    for (int unsigned k = 0; k < NREG; k++) begin
      wr_hit[k] = a_valid & ~a_nop & (a_dst == 4'(DST_REG0 + k));
    end
  end

  assign a_nop     = op_is_nop(a_op);
  assign a_to_port = a_valid & ~a_nop & (|a_port_sel);

  // Handshake: B frees when empty or draining; only port-bound tokens wait on B.
  assign b_drain  = en & (|(out_valid & out_ready));
  assign b_free   = ~(|out_valid) | b_drain;
  assign a_adv    = en & a_valid & (~a_to_port | b_free);
  assign in_ready = reset & en & (~a_valid | a_adv);
  assign accept   = in_valid & in_ready;

  // A token accepted on the edge a register is written must see the new value.
  always_comb begin
    for (int unsigned k = 0; k < NREG; k++) begin
      rf_fwd[k] = (a_adv && wr_hit[k]) ? alu_res : rf[k];
    end
    op1_nxt = sel_operand(ctrl_src1(ctrl), E, S, W, N, imm, rf_fwd);
    op2_nxt = sel_operand(ctrl_src2(ctrl), E, S, W, N, imm, rf_fwd);
  end

  // Stage A: capture operands on accept, empty when the token moves on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid <= 1'b0;
      a_op    <= OP_NOP;
      a_dst   <= '0;
      a_op1   <= '0;
      a_op2   <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_op    <= ctrl_op(ctrl);
      a_dst   <= ctrl_dst(ctrl);
      a_op1   <= op1_nxt;
      a_op2   <= op2_nxt;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  // Stage B: output register, reloaded from A or cleared once drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= '0;
      out_data  <= '0;
    end else if (a_adv && a_to_port) begin
      out_valid <= a_port_sel;
      out_data  <= alu_res;
    end else if (b_drain) begin
      out_valid <= '0;
    end
  end

  // Register file write on retirement of a register-bound token.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf <= '0;
    end else begin
      for (int unsigned k = 0; k < NREG; k++) begin
        if (a_adv && wr_hit[k]) rf[k] <= alu_res;
      end
    end
  end

  // Sticky divide-by-zero flag; clear has priority over a same-cycle set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_div0 <= 1'b0;
    end else if (en) begin
      if (err_clr) begin
        err_div0 <= 1'b0;
      end else if (a_adv && alu_div0) begin
        err_div0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_pipe.sv
// Scoreboard bench for pe_pipe: a program-order model predicts each port result.
`timescale 1ns/1ps
module tb_pe_pipe;
  import pe_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned NREGS = 4;

  typedef struct {
    logic [4:0]    port;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [15:0]   ctrl;
  logic [DW-1:0] imm, E, S, W, N;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready;
  logic          err_div0;
  logic          err_clr;

  exp_t          sb[$];
  exp_t          got_x;
  logic [DW-1:0] mreg [NREGS];
  int            n_vec = 0;
  int            n_err = 0;
  logic          rnd_on = 1'b0;

  always #5 clk = ~clk;

  pe_pipe #(.DATA_W(DW), .NREG(NREGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .ctrl      (ctrl),
    .imm       (imm),
    .E         (E),
    .S         (S),
    .W         (W),
    .N         (N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_div0  (err_div0),
    .err_clr   (err_clr)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_src(input logic [3:0] s, input logic [DW-1:0] ev,
                                          input logic [DW-1:0] sv, input logic [DW-1:0] wv,
                                          input logic [DW-1:0] nv, input logic [DW-1:0] iv);
    if (s == 4'd0) return ev;
    if (s == 4'd1) return sv;
    if (s == 4'd2) return wv;
    if (s == 4'd3) return nv;
    if (s >= 4'd4 && s <= 4'd7) return mreg[2'(s - 4'd4)];
    if (s == 4'd15) return iv;
    return '0;
  endfunction

  function automatic logic [DW-1:0] m_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      4'd1:  return a & b;
      4'd2:  return a ^ b;
      4'd3:  return a | b;
      4'd4:  return ~a;
      4'd5:  return a + b;
      4'd6:  return a - b;
      4'd7:  return a * b;
      4'd8:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd9:  return a << b[4:0];
      4'd10: return a >> b[4:0];
      4'd11: return (a < b) ? 32'd1 : 32'd0;
      4'd12: return a;
      default: return '0;
    endcase
  endfunction

  // Apply the token to the model, then present it until the DUT accepts it.
  task automatic send(input logic [3:0] dst, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] op, input logic [DW-1:0] ev, input logic [DW-1:0] sv,
                      input logic [DW-1:0] wv, input logic [DW-1:0] nv, input logic [DW-1:0] iv);
    logic [DW-1:0] a, b, r;
    exp_t x;
    int waited;
    a = m_src(s1, ev, sv, wv, nv, iv);
    b = m_src(s2, ev, sv, wv, nv, iv);
    r = m_alu(op, a, b);
    if (op != 4'd0 && op < 4'd13) begin
      if (dst <= 4'd4) begin
        x.port = 5'(5'd1 << dst);
        x.data = r;
        sb.push_back(x);
      end else if (dst >= 4'd5 && dst <= 4'd8) begin
        mreg[2'(dst - 4'd5)] = r;
      end
    end
    ctrl = {dst, s1, s2, op};
    E = ev; S = sv; W = wv; N = nv; imm = iv;
    in_valid = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || out_valid != 5'd0) && cyc < 500) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  // Scoreboard: compare every completed output handshake against the model.
  always @(negedge clk) begin
    if (reset === 1'b1 && en === 1'b1 && (out_valid & out_ready) != 5'd0) begin
      if (sb.size() == 0) begin
        check("out_unexpected", 32'(out_valid), 32'd0);
      end else begin
        got_x = sb.pop_front();
        check("out_port", 32'(out_valid), 32'(got_x.port));
        check("out_data", out_data, got_x.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b1; ctrl = '0; imm = '0; E = '0; S = '0; W = '0; N = '0;
    in_valid = 1'b0; out_ready = '0; err_clr = 1'b0;
    for (int k = 0; k < NREGS; k++) mreg[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_err", 32'(err_div0), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 check("idle_in_ready", 32'(in_ready), 32'd1);

    // 1: ADD E+S -> E, latency two edges
    out_ready = 5'h1F;
    send(4'd0, 4'd0, 4'd1, 4'd5, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0);
    check("t1_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid", 32'(out_valid), 32'h01);
    check("t1_data", out_data, 32'd12);
    wait_drain();

    // 2: backpressure on S
    out_ready = 5'b11101;
    send(4'd1, 4'd0, 4'd1, 4'd5, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0);
    send(4'd1, 4'd0, 4'd1, 4'd5, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("t2_stall", 32'(in_ready), 32'd0);
    check("t2_hold", out_data, 32'd3);
    fork
      send(4'd1, 4'd0, 4'd1, 4'd5, 32'd100, 32'd200, 32'd0, 32'd0, 32'd0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 5'h1F;
      end
    join
    wait_drain();

    // 3: register bypass, back-to-back
    send(4'd5, 4'd15, 4'd0, 4'd5, 32'd4, 32'd0, 32'd0, 32'd0, 32'd3);
    send(4'd3, 4'd4, 4'd0, 4'd12, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check("t3_valid", 32'(out_valid), 32'h08);
    check("t3_data", out_data, 32'd7);
    wait_drain();

    // 4: divide by zero, sticky flag, clear, clear beats set
    send(4'd4, 4'd0, 4'd1, 4'd8, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check("t4_valid", 32'(out_valid), 32'h10);
    check("t4_data", out_data, 32'hFFFF_FFFF);
    check("t4_err", 32'(err_div0), 32'd1);
    wait_drain();
    check("t4_sticky", 32'(err_div0), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("t4_clr", 32'(err_div0), 32'd0);
    send(4'd14, 4'd0, 4'd1, 4'd8, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("t4_clr_wins", 32'(err_div0), 32'd0);

    // 5: freeze with a pending result
    out_ready = 5'd0;
    send(4'd2, 4'd0, 4'd1, 4'd2, 32'hF0, 32'h3C, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1 check("t5_valid", 32'(out_valid), 32'h04);
    en = 1'b0;
    out_ready = 5'h1F;
    fork
      send(4'd0, 4'd0, 4'd1, 4'd3, 32'h11, 32'h22, 32'd0, 32'd0, 32'd0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("t5_no_accept", 32'(in_ready), 32'd0);
          check("t5_hold_valid", 32'(out_valid), 32'h04);
          check("t5_hold_data", out_data, 32'hCC);
        end
        @(posedge clk);
        #1 en = 1'b1;
      end
    join
    wait_drain();

    // 6: reset with two tokens in flight
    out_ready = 5'd0;
    send(4'd0, 4'd0, 4'd1, 4'd5, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0);
    send(4'd0, 4'd0, 4'd1, 4'd5, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    sb.delete();
    for (int k = 0; k < NREGS; k++) mreg[k] = '0;
    @(negedge clk);
    reset = 1'b1;
    out_ready = 5'h1F;
    @(posedge clk);
    #1;
    send(4'd0, 4'd4, 4'd0, 4'd12, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check("t6_reg0_valid", 32'(out_valid), 32'h01);
    check("t6_reg0_data", out_data, 32'd0);
    send(4'd1, 4'd15, 4'd0, 4'd9, 32'd31, 32'd0, 32'd0, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("t6_shl_valid", 32'(out_valid), 32'h02);
    check("t6_shl_data", out_data, 32'h8000_0000);
    wait_drain();

    // Random tokens under random backpressure and enable gaps
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
               4'($urandom_range(15)), $urandom, $urandom_range(40), $urandom,
               $urandom_range(3), $urandom);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = 5'($urandom);
          en = ($urandom_range(7) != 0);
        end
      end
    join
    en = 1'b1;
    out_ready = 5'h1F;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
